power_arbiter: RTL and testbench

Shares the ship's single reactor power bus among the three command-module subsystems: navigation (Position), weapons and shield (SaturationCounter). Each subsystem raises a request. A round-robin scheduler with a fixed time quantum grants the bus to one requester at a time and drives the 4-bit `mode` word and the `pwr` enable those blocks consume. An optional thermal lockout watches hull temperature and forces a shield-only cooldown phase.

---
 rtl/power_arbiter_if.sv | 15 +
 rtl/power_arbiter.sv | 143 ++++++++++++++
 tb/tb_power_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/power_arbiter_if.sv
// Reactor power bus bundle between the subsystems (master) and power_arbiter (slave).
// The subsystems drive req/temp; the arbiter drives grant/mode/pwr/lockout.
interface power_arbiter_if #(
   parameter int N = 5
);
   logic [2:0]   req;
   logic [N-1:0] temp;
   logic [2:0]   grant;
   logic [3:0]   mode;
   logic         pwr;
   logic         lockout;

   modport master (output req, temp, input grant, mode, pwr, lockout);
   modport slave  (input req, temp, output grant, mode, pwr, lockout);
endinterface

// File: rtl/power_arbiter.sv
// Round-robin, fixed-quantum arbiter for the reactor power bus (nav/weapons/shield).
// Optional thermal lockout with a shield-only cooldown is built with POWER_ARB_THERMAL_LOCK_EN.
module power_arbiter #(
   parameter int N       = 5,
   parameter int QUANTUM = 8,
   parameter int TEMP_HI = 28,
   parameter int TEMP_LO = 16
) (
   input  logic           clk,
   input  logic           rst,
   power_arbiter_if.slave bus
);
   localparam int QW = $clog2(QUANTUM);
   localparam logic [QW-1:0] QMAX = QW'(QUANTUM - 1);

   typedef enum logic [1:0] {IDLE, GRANT, SWITCH, COOL} state_t;

   state_t        state_q, state_d;
   logic [1:0]    owner_q, owner_d;
   logic [1:0]    ptr_q, ptr_d;
   logic [QW-1:0] qcnt_q, qcnt_d;
   logic [2:0]    grant_q, grant_d;
   logic [2:0]    pick;
   logic          thermal;

   // Returns {found, index} of the first requester at or after p, wrapping mod 3.
   function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
      logic [2:0] res;
      logic [1:0] cand;
      res = 3'b000;
      for (int i = 0; i < 3; i++) begin
         cand = 2'((int'(p) + i) % 3);
         if (!res[2] && r[cand]) res = {1'b1, cand};
      end
      return res;
   endfunction

   function automatic logic [1:0] next_ptr(input logic [1:0] o);
      return (o == 2'd2) ? 2'd0 : o + 2'd1;
   endfunction

`ifdef POWER_ARB_THERMAL_LOCK_EN
   logic lockout_q, lockout_d;
   logic cool_exit;
   assign thermal   = int'(bus.temp) >= TEMP_HI;
   assign cool_exit = int'(bus.temp) <= TEMP_LO;
   assign bus.lockout = lockout_q;
`else
   logic unused_temp;
   assign thermal     = 1'b0;
   assign unused_temp = ^bus.temp;
   assign bus.lockout = 1'b0;
`endif

   assign pick = rr_pick(bus.req, ptr_q);

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      qcnt_d  = qcnt_q;
      grant_d = 3'b000;
`ifdef POWER_ARB_THERMAL_LOCK_EN
      lockout_d = 1'b0;
`endif
      case (state_q)
         IDLE, SWITCH: begin
            if (thermal) begin
               state_d = COOL;
            end else if (pick[2]) begin
               owner_d = pick[1:0];
               qcnt_d  = '0;
               state_d = GRANT;
            end else begin
               state_d = IDLE;
            end
         end
         GRANT: begin
            // A shield owner is already the cooldown consumer, so heat does not evict it.
            if (thermal && owner_q != 2'd2) begin
               state_d = COOL;
               ptr_d   = next_ptr(owner_q);
            end else if (!bus.req[owner_q]) begin
               state_d = SWITCH;
               ptr_d   = next_ptr(owner_q);
            end else if (qcnt_q == QMAX) begin
               if ((bus.req & ~(3'b001 << owner_q)) != 3'b000) begin
                  state_d = SWITCH;
                  ptr_d   = next_ptr(owner_q);
               end else begin
                  qcnt_d = '0;
               end
            end else begin
               qcnt_d = qcnt_q + 1'b1;
            end
         end
`ifdef POWER_ARB_THERMAL_LOCK_EN
         COOL: begin
            if (cool_exit) state_d = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase

      // Outputs are registered from the next state so they line up with it.
      case (state_d)
         GRANT: grant_d = 3'b001 << owner_d;
`ifdef POWER_ARB_THERMAL_LOCK_EN
         COOL: begin
            grant_d   = {bus.req[2], 2'b00};
            lockout_d = 1'b1;
         end
`endif
         default: grant_d = 3'b000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= 2'd0;
         ptr_q   <= 2'd0;
         qcnt_q  <= '0;
         grant_q <= 3'b000;
`ifdef POWER_ARB_THERMAL_LOCK_EN
         lockout_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         qcnt_q  <= qcnt_d;
         grant_q <= grant_d;
`ifdef POWER_ARB_THERMAL_LOCK_EN
         lockout_q <= lockout_d;
`endif
      end
   end

   assign bus.grant = grant_q;
   assign bus.mode  = {1'b0, grant_q};
   assign bus.pwr   = |grant_q;
endmodule

// File: tb/tb_power_arbiter.sv
// Randomized scoreboard bench for power_arbiter against a cycle-level behavioural model.
// Builds for either setting of POWER_ARB_THERMAL_LOCK_EN.
module tb_power_arbiter;
   localparam int N  = 5;
   localparam int Q  = 4;
   localparam int HI = 28;
   localparam int LO = 16;
`ifdef POWER_ARB_THERMAL_LOCK_EN
   localparam bit THERM = 1'b1;
`else
   localparam bit THERM = 1'b0;
`endif

   typedef struct packed {
      logic [2:0] grant;
      logic       lockout;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   power_arbiter_if #(.N(N)) bus ();

   power_arbiter #(.N(N), .QUANTUM(Q), .TEMP_HI(HI), .TEMP_LO(LO)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   // Model: who holds the bus (-1 = nobody), how many cycles it has shown,
   // whether we are cooling, and where the next search starts.
   int         m_cur  = -1;
   int         m_held = 0;
   int         m_ptr  = 0;
   bit         m_cool = 1'b0;
   logic [2:0] m_gnt  = 3'b000;

   function automatic void model_step(input bit r_rst, input logic [2:0] r, input int t);
      bit hot;
      bit others;
      hot = THERM && (t >= HI);
      if (r_rst) begin
         m_cur = -1; m_held = 0; m_ptr = 0; m_cool = 1'b0; m_gnt = 3'b000;
      end else if (m_cool) begin
         if (t <= LO) begin
            m_cool = 1'b0;
            m_gnt  = 3'b000;
         end else begin
            m_gnt = r[2] ? 3'b100 : 3'b000;
         end
      end else if (m_cur >= 0) begin
         others = (r & ~(3'b001 << m_cur)) != 3'b000;
         if (hot && m_cur != 2) begin
            m_ptr = (m_cur + 1) % 3; m_cur = -1; m_cool = 1'b1;
            m_gnt = r[2] ? 3'b100 : 3'b000;
         end else if (!r[m_cur] || (m_held == Q && others)) begin
            m_ptr = (m_cur + 1) % 3; m_cur = -1; m_gnt = 3'b000;
         end else begin
            m_held = (m_held == Q) ? 1 : m_held + 1;
         end
      end else if (hot) begin
         m_cool = 1'b1;
         m_gnt  = r[2] ? 3'b100 : 3'b000;
      end else begin
         m_gnt = 3'b000;
         for (int k = 0; k < 3; k++) begin
            int w;
            w = (m_ptr + k) % 3;
            if (m_cur < 0 && r[w]) begin
               m_cur = w; m_held = 1; m_gnt = 3'b001 << w;
            end
         end
      end
   endfunction

   task automatic apply(input bit r_rst, input logic [2:0] r, input int t);
      exp_t e;
      @(negedge clk);
      rst      = r_rst;
      bus.req  = r;
      bus.temp = N'(t);
      model_step(r_rst, r, t);
      e.grant   = m_gnt;
      e.lockout = m_cool;
      sbq.push_back(e);
   endtask

   task automatic chk(input string nm, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, got, want);
      end
   endtask

   // Monitor: one expected entry per edge, compared just after that edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            cyc++;
            chk("grant",   int'(bus.grant),   int'(e.grant));
            chk("mode",    int'(bus.mode),    int'({1'b0, e.grant}));
            chk("pwr",     int'(bus.pwr),     int'(|e.grant));
            chk("lockout", int'(bus.lockout), int'(e.lockout));
            chk("onehot",  int'($onehot0(bus.grant)), 1);
         end
      end
   end

   initial begin
      logic [2:0] r;
      int         t;
      bus.req  = 3'b000;
      bus.temp = '0;

      repeat (2) apply(1'b1, 3'b111, 0);
      repeat (10) apply(1'b0, 3'b001, 0);
      repeat (30) apply(1'b0, 3'b111, 0);
      // Hot hull during contention, then cool down in steps.
      repeat (6) apply(1'b0, 3'b011, 31);
      repeat (4) apply(1'b0, 3'b110, 29);
      repeat (3) apply(1'b0, 3'b110, 20);
      repeat (12) apply(1'b0, 3'b111, 16);

      r = 3'b000;
      repeat (250) begin
         if ($urandom_range(0, 3) == 0) r = 3'($urandom_range(0, 7));
         apply(1'b0, r, int'($urandom_range(0, LO)));
      end

      t = 10;
      repeat (500) begin
         if ($urandom_range(0, 3) == 0) r = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 39) == 0) t = int'($urandom_range(0, 31));
         else t = t + int'($urandom_range(0, 6)) - 3;
         if (t < 0) t = 0;
         if (t > 31) t = 31;
         apply(($urandom_range(0, 149) == 0), r, t);
      end

      apply(1'b1, 3'b111, 0);
      repeat (5) apply(1'b0, 3'b111, 0);

      for (int i = 0; i < 20 && sbq.size() > 0; i++) @(posedge clk);
      #2;
      if (sbq.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain pending=%0d expected=0", sbq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
